// File: rtl/divider_pkg.sv
// Shared core execute-stage types.
//   mult_type_t : operation select for the pipelined multiplier
//   div_type_t  : operation select for the iterative divider
//   micro_op_t  : decoded micro-op carried down the execute stage
package divider_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned CORE_TAG_BITS = 6;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mult_type_t;

    typedef enum logic [1:0] {
        DIV  = 2'd0,
        DIVU = 2'd1,
        REM  = 2'd2,
        REMU = 2'd3
    } div_type_t;

    typedef struct packed {
        logic [CORE_TAG_BITS-1:0] tag;
        mult_type_t               mult_type;
        div_type_t                div_type;
        logic [XLEN-1:0]          rs1;
        logic [XLEN-1:0]          rs2;
    } micro_op_t;

endpackage

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One operation per in_valid/in_ready handshake; 32 shift/subtract cycles
// plus one sign-fix cycle; result held under out_valid/out_ready.
// Ports:
//   clock, reset (async, active-low), flush (sync kill of op in flight)
//   in_valid/in_ready, div_type, in1 (dividend), in2 (divisor), in_tag
//   out_valid/out_ready, out (quotient or remainder), out_tag
module divider
    import divider_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  div_type_t            div_type,
    input  logic [31:0]          in1,
    input  logic [31:0]          in2,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out,
    output logic [TAG_WIDTH-1:0] out_tag
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [31:0]            rem_q, rem_d;
    logic [31:0]            quo_q, quo_d;
    logic [31:0]            divisor_q, divisor_d;
    div_type_t              type_q, type_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   neg_quo_q, neg_quo_d;
    logic                   neg_rem_q, neg_rem_d;
    logic [31:0]            out_q, out_d;
    logic [TAG_WIDTH-1:0]   out_tag_q, out_tag_d;

    logic        signed_op, is_div_in, a_neg, b_neg;
    logic [31:0] abs_a, abs_b;
    logic [32:0] shifted, trial;
    logic [31:0] quo_fix, rem_fix;

    assign in_ready  = (state_q == IDLE) && reset;
    assign out_valid = (state_q == DONE);
    assign out       = out_q;
    assign out_tag   = out_tag_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        divisor_d = divisor_q;
        type_d    = type_q;
        tag_d     = tag_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        out_d     = out_q;
        out_tag_d = out_tag_q;

        signed_op = (div_type == DIV) || (div_type == REM);
        is_div_in = (div_type == DIV) || (div_type == DIVU);
        a_neg     = signed_op && in1[31];
        b_neg     = signed_op && in2[31];
        abs_a     = a_neg ? (32'd0 - in1) : in1;
        abs_b     = b_neg ? (32'd0 - in2) : in2;

        // rem < divisor always holds, so the shifted partial remainder fits
        // in 33 bits and bit 32 of the difference is its sign.
        shifted   = {rem_q, quo_q[31]};
        trial     = shifted - {1'b0, divisor_q};

        quo_fix   = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        rem_fix   = neg_rem_q ? (32'd0 - rem_q) : rem_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready && !flush) begin
                    type_d    = div_type;
                    tag_d     = in_tag;
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    divisor_d = abs_b;
                    quo_d     = abs_a;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (in2 == '0) begin
                        out_d     = is_div_in ? '1 : in1;
                        out_tag_d = in_tag;
                        state_d   = DONE;
                    end else if (signed_op && (in1 == 32'h8000_0000) && (in2 == '1)) begin
                        out_d     = is_div_in ? 32'h8000_0000 : '0;
                        out_tag_d = in_tag;
                        state_d   = DONE;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (trial[32]) begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end else begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                out_d     = ((type_q == DIV) || (type_q == DIVU)) ? quo_fix : rem_fix;
                out_tag_d = tag_q;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            state_d   = IDLE;
            out_d     = out_q;
            out_tag_d = out_tag_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            type_q    <= DIV;
            tag_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            out_q     <= '0;
            out_tag_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            divisor_q <= divisor_d;
            type_q    <= type_d;
            tag_q     <= tag_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            out_q     <= out_d;
            out_tag_q <= out_tag_d;
        end
    end

endmodule

// File: doc/divider.md
# divider

Iterative radix-2 restoring integer divider for the RV32M DIV/DIVU/REM/REMU group; the inverse-operation companion to the pipelined `mult` unit in the execute stage. It takes one operation per `in_valid`/`in_ready` handshake and runs 32 shift/subtract iterations plus one sign-fix cycle. It holds the result under `out_valid`/`out_ready` back-pressure until writeback accepts it. A flush discards any operation in flight.

## Interface
- `TAG_WIDTH`, 6, width of the destination tag carried with the operation.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces reset state immediately.
- `flush`  in  1  synchronous kill of the operation in flight.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  divider can accept; equals (state==IDLE) && reset.
- `div_type`  in  2  `div_type_t`: DIV, DIVU, REM, REMU.
- `in1`  in  32  dividend (rs1).
- `in2`  in  32  divisor (rs2).
- `in_tag`  in  TAG_WIDTH  destination tag.
- `out_valid`  out  1  result valid (state==DONE).
- `out_ready`  in  1  consumer takes the result.
- `out`  out  32  quotient or remainder.
- `out_tag`  out  TAG_WIDTH  tag of `out`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- Accept: `in_valid && in_ready && !flush`. The unit latches type, tag, the operand signs, and |in1|, |in2|. Absolute values apply only to DIV/REM; DIVU/REMU use raw operands.
- Fast path from IDLE straight to DONE:
  - Divisor 0: DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> in1.
  - DIV/REM with in1=0x80000000 and in2=0xFFFFFFFF: DIV -> 0x80000000; REM -> 0.
- IDLE -> CALC for all other accepted operations; 5-bit counter starts at 0.
- CALC iteration, done each cycle:
  - Shift {rem, quo} left by 1.
  - Trial = rem - divisor, computed 33 bits wide.
  - If the trial is non-negative, rem = trial and quo[0] = 1.
  - Leave CALC for FIX when counter==31.
- FIX: signed types only.
  - Quotient negated when the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - Select quo for DIV/DIVU and rem for REM/REMU, then register into `out`.
  - FIX -> DONE.
- DONE: `out`, `out_tag` and `out_valid` are held stable. DONE -> IDLE on `out_ready`.
- `in_ready` is low in DONE, so accept and hand-off never share a cycle.
- Flush: any state -> IDLE at the next edge; `out_valid` drops; no result is produced.
  - Flush wins over a simultaneous `in_valid` (no accept).
  - Flush also wins over a simultaneous `out_ready` (result dropped, not handed off).
- Reset values: state IDLE, `out_valid` 0, `out` 0, `out_tag` 0, counter 0, `in_ready` 0 while `reset` is low.

## Timing
- Cycle 0 is the accept cycle.
- Normal path: CALC occupies cycles 1-32, FIX is cycle 33, `out_valid` rises in cycle 34.
- Fast path: `out_valid` rises in cycle 1.
- Latency does not depend on operand values except for the fast path.
- Minimum issue interval:
  - Normal: 35 cycles (result taken in cycle 34, next accept in cycle 35).
  - Fast path: 2 cycles.
- Reset asserted mid-operation aborts immediately. After release, `in_ready` is 1 in the first cycle.

## Structure
- The shared core package gets a `div_type_t` enum (DIV, DIVU, REM, REMU), alongside `mult_type_t`, plus a `div_type` field in `micro_op_t`.
- The state enum is local to `divider`.
- No sub-module is needed; the iteration datapath is inline.

## Test plan
- DIVU 100/7 -> `out`=14 in cycle 34 with tag echoed; REMU 100/7 -> 2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, both in cycle 1.
- `out_ready` low for 10 cycles after `out_valid`: `out` and `out_tag` stable, `in_ready` 0. A new op offered during that window is accepted only in the cycle after `out_ready`.
- `flush` in cycle 10 of CALC: `in_ready` is 1 in cycle 11 and `out_valid` never rises. Flush together with `in_valid` in IDLE: not accepted.
- `reset` pulsed low in cycle 20 of CALC: `out_valid` 0 and `out` 0 immediately. A DIVU 9/3 issued after release -> 3 in cycle 34.
